dlfloat_link_host: RTL and testbench

Host-side link controller for the byte-serial DLFloat16 MAC tile. It accepts DLFloat16 operand pairs on a valid/ready interface and drives them onto the 16-bit device input bus in the two-phase frame the tile expects. It captures the tile's byte-serial result stream, reassembles each 16-bit accumulator value and emits one result per issued operation. It sits between a system-side producer/consumer and the tile's pad-level ports, on the same clock and reset.

---
 rtl/dlfloat_pkg.sv | 32 +++
 rtl/dlfloat_link_host_if.sv | 31 +++
 rtl/dlfloat_op_fifo.sv | 62 ++++++
 rtl/dlfloat_link_host.sv | 122 ++++++++++++
 tb/tb_dlfloat_link_host.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dlfloat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_pkg
// Purpose  : DLFloat16 field layout, well-known constants and the operand
//            pair type shared by the link host and its operand buffer.
// Revision : 1.0  initial release
// ============================================================================
package dlfloat_pkg;

   // DLFloat16 layout: {sign, exp[5:0] bias 31, mant[8:0]}
   localparam int SIGN_BIT  = 15;
   localparam int EXP_MSB   = 14;
   localparam int EXP_LSB   = 9;
   localparam int MANT_MSB  = 8;
   localparam int MANT_LSB  = 0;
   localparam int EXP_BIAS  = 31;

   localparam logic [15:0] DLF_NAN = 16'hFFFF;
   localparam logic [15:0] DLF_ONE = 16'h3E00;

   // Cycles per link frame (operand A phase, operand B phase)
   localparam int FRAME_LEN = 2;

   typedef logic [15:0] dlf16_t;

   typedef struct packed {
      dlf16_t a;
      dlf16_t b;
   } dlf_pair_t;

endpackage
`default_nettype wire

// File: rtl/dlfloat_link_host_if.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_link_host_if
// Purpose  : System-side operand (valid/ready) and result (pulse) channels
//            of the DLFloat16 link host.
// Revision : 1.0  initial release
// ============================================================================
interface dlfloat_link_host_if;
   import dlfloat_pkg::*;

   logic   op_valid;
   logic   op_ready;
   dlf16_t op_a;
   dlf16_t op_b;
   logic   res_valid;
   dlf16_t res_data;

   // Producer/consumer side
   modport master (
      output op_valid, op_a, op_b,
      input  op_ready, res_valid, res_data
   );

   // Link host side
   modport slave (
      input  op_valid, op_a, op_b,
      output op_ready, res_valid, res_data
   );

endinterface
`default_nettype wire

// File: rtl/dlfloat_op_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_op_fifo
// Purpose  : 2-entry operand-pair FIFO. Entry 0 is always the head; a pop
//            shifts entry 1 down. Also exposes the entry behind the head so
//            the caller can look one pop ahead.
// Revision : 1.0  initial release
// ============================================================================
module dlfloat_op_fifo
   import dlfloat_pkg::*;
(
   input  wire logic      clk,
   input  wire logic      rst_n,
   input  wire logic      i_push,
   input  wire logic      i_pop,
   input  wire dlf_pair_t i_wdata,
   output dlf_pair_t      o_head,
   output dlf_pair_t      o_second,
   output logic [1:0]     o_count,
   output logic           o_full,
   output logic           o_empty
);

   dlf_pair_t  r_mem0;
   dlf_pair_t  r_mem1;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_full   = (r_count == 2'd2);
   assign o_empty  = (r_count == 2'd0);
   assign o_count  = r_count;
   assign o_head   = r_mem0;
   assign o_second = r_mem1;

   // Requests that would overflow or underflow are dropped
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // Storage and occupancy update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem0  <= '0;
         r_mem1  <= '0;
         r_count <= 2'd0;
      end else begin
         if (w_push && w_pop) begin
            // Only reachable with one entry held: replace it in place
            r_mem0 <= i_wdata;
         end else if (w_pop) begin
            r_mem0  <= r_mem1;
            r_count <= r_count - 2'd1;
         end else if (w_push) begin
            if (r_count == 2'd0) r_mem0 <= i_wdata;
            else                 r_mem1 <= i_wdata;
            r_count <= r_count + 2'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dlfloat_link_host.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_link_host
// Purpose  : Host-side link controller for the byte-serial DLFloat16 MAC
//            tile. Frames buffered operand pairs onto the 16-bit device bus,
//            tracks real/idle frames through a tag pipeline and reassembles
//            the tile's byte-serial accumulator results.
// Revision : 1.0  initial release
// ============================================================================
module dlfloat_link_host
   import dlfloat_pkg::*;
#(
   parameter int RESULT_LAT = 3,   // frames from operand commit to result frame, 1..15
   parameter int CNT_W      = 16
)(
   input  wire logic             clk,
   input  wire logic             rst_n,
   dlfloat_link_host_if.slave    bus,
   output logic [15:0]           link_out,
   input  wire logic [7:0]       dev_byte,
   output logic                  busy,
   output logic [CNT_W-1:0]      ops_issued,
   output logic [CNT_W-1:0]      ops_returned
);

   logic                  r_phase;     // 0: operand A cycle, 1: operand B cycle
   logic                  r_real;      // current frame carries a buffered op
   logic [15:0]           r_link;
   logic [RESULT_LAT-1:0] r_tag;
   logic [7:0]            r_low;
   logic                  r_pend;      // result high byte is on dev_byte this cycle
   logic [CNT_W-1:0]      r_issued;
   logic [CNT_W-1:0]      r_returned;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [1:0]            w_count;
   logic [1:0]            w_rem;
   logic                  w_launch;
   dlf_pair_t             w_head;
   dlf_pair_t             w_second;
   dlf_pair_t             w_wdata;
   dlf_pair_t             w_next_head;
   logic [RESULT_LAT-1:0] w_tag_shift;

   assign w_wdata = '{a: bus.op_a, b: bus.op_b};
   assign w_push  = bus.op_valid & ~w_full;
   // The launched entry leaves the buffer once its B phase has been driven
   assign w_pop   = r_phase & r_real;

   dlfloat_op_fifo u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_wdata  (w_wdata),
      .o_head   (w_head),
      .o_second (w_second),
      .o_count  (w_count),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   // Look past this edge's pop and push so an op accepted in phase 1
   // launches in the very next phase 0.
   assign w_rem       = w_count - {1'b0, w_pop};
   assign w_launch    = (w_rem != 2'd0) | w_push;
   assign w_next_head = (w_rem == 2'd0) ? w_wdata : (w_pop ? w_second : w_head);

   generate
      if (RESULT_LAT == 1) begin : g_tag_single
         assign w_tag_shift = r_real;
      end else begin : g_tag_multi
         assign w_tag_shift = {r_tag[RESULT_LAT-2:0], r_real};
      end
   endgenerate

   // Frame sequencing, bus drive, capture, tag pipeline and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= 1'b0;
         r_real     <= 1'b0;
         r_link     <= 16'h0000;
         r_tag      <= '0;
         r_low      <= 8'h00;
         r_pend     <= 1'b0;
         r_issued   <= '0;
         r_returned <= '0;
      end else begin
         r_phase <= ~r_phase;
         if (r_phase) begin
            // End of phase 1: decide the next frame, advance tags, take low byte
            r_real <= w_launch;
            r_link <= w_launch ? w_next_head.a : 16'h0000;
            r_tag  <= w_tag_shift;
            r_low  <= dev_byte;
            r_pend <= r_tag[RESULT_LAT-1];
         end else begin
            // End of phase 0: drive operand B, retire the emitted result
            r_link <= r_real ? w_head.b : 16'h0000;
            r_pend <= 1'b0;
            if (r_real) r_issued   <= r_issued + CNT_W'(1);
            if (r_pend) r_returned <= r_returned + CNT_W'(1);
         end
      end
   end

   // The high byte is forwarded in the cycle it is presented, which keeps
   // the result latency at 2*RESULT_LAT+2 cycles after launch.
   assign bus.res_valid = r_pend;
   assign bus.res_data  = r_pend ? {dev_byte, r_low} : 16'h0000;
   assign bus.op_ready  = ~w_full;

   assign link_out     = r_link;
   assign busy         = ~w_empty | (|r_tag) | r_pend;
   assign ops_issued   = r_issued;
   assign ops_returned = r_returned;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_link_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat_link_host
// Purpose  : Self-checking bench for dlfloat_link_host with a byte-serial
//            tile model and a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_dlfloat_link_host;
   import dlfloat_pkg::*;

   localparam int L  = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   link_out;
   logic [7:0]    dev_byte;
   logic          busy;
   logic [CW-1:0] ops_issued;
   logic [CW-1:0] ops_returned;

   int n_checks = 0;
   int n_errors = 0;

   dlfloat_link_host_if bus ();

   dlfloat_link_host #(.RESULT_LAT(L), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .link_out     (link_out),
      .dev_byte     (dev_byte),
      .busy         (busy),
      .ops_issued   (ops_issued),
      .ops_returned (ops_returned)
   );

   always #5 clk = ~clk;

   // Cycle index since reset release; cycle 0 is phase 0
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // ---------------- tile model ----------------
   function automatic logic [15:0] tile_fn(input logic [15:0] a, input logic [15:0] b);
      if (a == DLF_ONE && b == DLF_ONE) return DLF_ONE;
      return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
   endfunction

   int          tf;
   logic        tph;
   logic [15:0] ta;
   logic [15:0] hist [0:2047];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tf  <= 0;
         tph <= 1'b0;
      end else begin
         tph <= ~tph;
         if (tph) tf <= tf + 1;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (!tph) ta <= link_out;
         else      hist[tf % 2048] <= tile_fn(ta, link_out);
      end
   end

   // Result of frame k: low byte in phase 1 of frame k+L, high in phase 0 of k+L+1
   always_comb begin
      dev_byte = 8'h00;
      if (rst_n) begin
         if (tph && tf >= L)           dev_byte = hist[(tf - L) % 2048][7:0];
         else if (!tph && tf >= L + 1) dev_byte = hist[(tf - 1 - L) % 2048][15:8];
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [15:0] val;
      int          cyc;
   } exp_t;

   exp_t sb [$];
   int   res_log [$];
   int   last_launch = -10;
   exp_t mon_e;

   always @(negedge clk) begin
      if (rst_n && bus.res_valid) begin
         res_log.push_back(cyc);
         n_checks++;
         if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL res_unexpected: got %h at cycle %0d, required no result", bus.res_data, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (bus.res_data !== mon_e.val || cyc != mon_e.cyc) begin
               n_errors++;
               $display("FAIL res_data: got %h at cycle %0d, required %h at cycle %0d",
                        bus.res_data, cyc, mon_e.val, mon_e.cyc);
            end
         end
      end
   end

   // Offer one op starting at a negedge; returns at the negedge after acceptance
   task automatic send_op(input logic [15:0] a, input logic [15:0] b);
      int   w;
      int   nxt;
      exp_t e;
      bus.op_valid = 1'b1;
      bus.op_a     = a;
      bus.op_b     = b;
      w = 0;
      while (!bus.op_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!bus.op_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: op_ready got %b, required 1", bus.op_ready);
      end else begin
         nxt = (cyc % 2 == 1) ? cyc + 1 : cyc + 2;
         if (nxt < last_launch + 2) nxt = last_launch + 2;
         last_launch = nxt;
         e.val = tile_fn(a, b);
         e.cyc = nxt + 2 * L + 2;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((sb.size() != 0 || busy) && w < 200) begin
         @(negedge clk);
         w++;
      end
      n_checks++;
      if (sb.size() != 0 || busy) begin
         n_errors++;
         $display("FAIL drain_timeout: pending got %0d busy %b, required 0 and 0", sb.size(), busy);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n        = 1'b0;
      bus.op_valid = 1'b0;
      sb.delete();
      res_log.delete();
      last_launch = -10;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic align_phase(input int p);
      while (cyc % 2 != p) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.op_ready !== 1'b1 || link_out !== 16'h0 || bus.res_valid !== 1'b0 ||
          bus.res_data !== 16'h0 || busy !== 1'b0 || ops_issued !== '0 || ops_returned !== '0) begin
         n_errors++;
         $display("FAIL reset_values: got rdy %b link %h rv %b rd %h busy %b iss %0d ret %0d, required 1 0000 0 0000 0 0 0",
                  bus.op_ready, link_out, bus.res_valid, bus.res_data, busy, ops_issued, ops_returned);
      end
      do_reset();
   endtask

   task automatic test_single();
      logic [15:0] exp_bus [3];
      int l;
      exp_bus[0] = DLF_ONE;
      exp_bus[1] = DLF_ONE;
      exp_bus[2] = 16'h0000;
      align_phase(0);
      send_op(DLF_ONE, DLF_ONE);
      l = last_launch;
      while (cyc < l) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (link_out !== exp_bus[i]) begin
            n_errors++;
            $display("FAIL single_link_%0d: got %h, required %h", i, link_out, exp_bus[i]);
         end
         @(negedge clk);
      end
      drain();
      n_checks++;
      if (ops_issued !== CW'(1) || ops_returned !== CW'(1) || res_log.size() != 1) begin
         n_errors++;
         $display("FAIL single_counts: got iss %0d ret %0d results %0d, required 1 1 1",
                  ops_issued, ops_returned, res_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      int n0;
      align_phase(1);
      c0 = cyc;
      n0 = res_log.size();
      send_op(16'h4100, 16'hC080);
      send_op(16'h3F00, 16'h0123);
      n_checks++;
      if (bus.op_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_ready_low: got %b, required 0", bus.op_ready);
      end
      send_op(16'h1357, 16'h2468);
      n_checks++;
      if (cyc != c0 + 4 || last_launch != c0 + 5) begin
         n_errors++;
         $display("FAIL b2b_third_accept: got return cycle %0d launch %0d, required %0d %0d",
                  cyc, last_launch, c0 + 4, c0 + 5);
      end
      drain();
      n_checks++;
      if (res_log.size() != n0 + 3 || res_log[n0 + 1] - res_log[n0] != 2 ||
          res_log[n0 + 2] - res_log[n0 + 1] != 2) begin
         n_errors++;
         $display("FAIL b2b_spacing: got %0d results, required 3 pulses 2 cycles apart", res_log.size() - n0);
      end
   endtask

   task automatic test_phase1_offer();
      align_phase(1);
      n_checks++;
      if (link_out !== 16'h0) begin
         n_errors++;
         $display("FAIL p1_offer_idle: got %h, required 0000", link_out);
      end
      send_op(16'hABCD, 16'h5A5A);
      n_checks++;
      if (link_out !== 16'hABCD) begin
         n_errors++;
         $display("FAIL p1_launch_a: got %h, required abcd", link_out);
      end
      @(negedge clk);
      n_checks++;
      if (link_out !== 16'h5A5A) begin
         n_errors++;
         $display("FAIL p1_launch_b: got %h, required 5a5a", link_out);
      end
      drain();
   endtask

   task automatic test_idle();
      logic [CW-1:0] iss0;
      logic [CW-1:0] ret0;
      iss0 = ops_issued;
      ret0 = ops_returned;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (link_out !== 16'h0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_cycle_%0d: got link %h rv %b busy %b, required 0000 0 0",
                     i, link_out, bus.res_valid, busy);
         end
      end
      n_checks++;
      if (ops_issued !== iss0 || ops_returned !== ret0) begin
         n_errors++;
         $display("FAIL idle_counts: got %0d %0d, required %0d %0d", ops_issued, ops_returned, iss0, ret0);
      end
   endtask

   task automatic test_reset_midframe();
      align_phase(1);
      send_op(16'h1111, 16'h2222);
      send_op(16'h3333, 16'h4444);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.op_ready !== 1'b1 || link_out !== 16'h0 || bus.res_valid !== 1'b0 ||
          bus.res_data !== 16'h0 || busy !== 1'b0 || ops_issued !== '0 || ops_returned !== '0) begin
         n_errors++;
         $display("FAIL midreset_values: got rdy %b link %h rv %b rd %h busy %b iss %0d ret %0d, required 1 0000 0 0000 0 0 0",
                  bus.op_ready, link_out, bus.res_valid, bus.res_data, busy, ops_issued, ops_returned);
      end
      sb.delete();
      res_log.delete();
      last_launch = -10;
      @(negedge clk);
      rst_n = 1'b1;
      send_op(16'h6789, 16'h0F0F);
      @(negedge clk);
      n_checks++;
      if (cyc != 2 || link_out !== 16'h6789) begin
         n_errors++;
         $display("FAIL midreset_launch: got %h at cycle %0d, required 6789 at cycle 2", link_out, cyc);
      end
      drain();
      n_checks++;
      if (res_log.size() != 1 || ops_issued !== CW'(1) || ops_returned !== CW'(1)) begin
         n_errors++;
         $display("FAIL midreset_counts: got results %0d iss %0d ret %0d, required 1 1 1",
                  res_log.size(), ops_issued, ops_returned);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) send_op(16'($urandom), 16'($urandom));
      drain();
      n_checks++;
      if (ops_issued !== CW'(1) || ops_returned !== CW'(1) || res_log.size() != 17) begin
         n_errors++;
         $display("FAIL wrap_counts: got iss %0d ret %0d results %0d, required 1 1 17",
                  ops_issued, ops_returned, res_log.size());
      end
   endtask

   initial begin
      bus.op_valid = 1'b0;
      bus.op_a     = 16'h0;
      bus.op_b     = 16'h0;
      test_reset();
      test_single();
      test_back_to_back();
      test_phase1_offer();
      test_idle();
      test_reset_midframe();
      test_wrap();
      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
